// File: rtl/apb_mem_ctrl_if.sv
// APB3 bus bundle between the interconnect (master) and apb_mem_ctrl (slave).
interface apb_mem_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );
endinterface

// File: rtl/apb_mem_ctrl.sv
// APB3 completer sequencing a single-port word memory (sync write, comb read, write-protect).
// Optional macro APB_WAIT_STATE_EN inserts WAIT_CYCLES wait states in ACCESS.
module apb_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    apb_mem_ctrl_if.slave         apb,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_err
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    state_e r_state;
    state_e w_state_next;
    logic   w_wait_done;
    logic   w_done;
    logic   w_decode_err;
    logic   w_bus_rd;

    // ------------------------------------------------------------------
    // Wait-state counter
    // ------------------------------------------------------------------
`ifdef APB_WAIT_STATE_EN
    localparam logic [3:0] WaitEff = 4'(WAIT_CYCLES);

    logic [3:0] r_wait_cnt;

    // Held at zero outside ACCESS, so it is clear on every ACCESS entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state != StAccess) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != WaitEff) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign w_wait_done = (r_wait_cnt == WaitEff);
`else
    assign w_wait_done = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                // psel & penable without a setup cycle is ignored.
                if (apb.psel && !apb.penable) begin
                    w_state_next = StSetup;
                end
            end
            StSetup: begin
                if (!apb.psel) begin
                    w_state_next = StIdle;
                end else if (apb.penable) begin
                    w_state_next = StAccess;
                end
            end
            StAccess: begin
                if (w_done) begin
                    w_state_next = (apb.psel && !apb.penable) ? StSetup : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    assign w_decode_err = (apb.paddr[31:ADDR_WIDTH+2] != '0) || (apb.paddr[1:0] != 2'b00);

    // Reset forces every output low, even before the first reset edge.
    assign w_done = !i_rst && (r_state == StAccess) && apb.psel && apb.penable && w_wait_done;
    assign w_bus_rd = !i_rst && apb.psel;

    always_comb begin
        apb.pready  = w_done;
        apb.pslverr = w_done && (w_decode_err || (apb.pwrite && i_mem_err));
        apb.prdata  = '0;
        if (w_done && !apb.pwrite && !w_decode_err) begin
            apb.prdata = i_mem_rdata;
        end
        o_mem_we    = w_done && apb.pwrite && !w_decode_err;
        o_mem_addr  = w_bus_rd ? apb.paddr[ADDR_WIDTH+1:2] : '0;
        o_mem_wdata = w_bus_rd ? apb.pwdata : '0;
    end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Randomized scoreboard bench for apb_mem_ctrl with a word memory holding reset content = index.
module tb_apb_mem_ctrl;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;
`ifdef APB_WAIT_STATE_EN
    localparam int unsigned WAIT_EFF = 2;
`else
    localparam int unsigned WAIT_EFF = 0;
`endif

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    always #5 clk = ~clk;

    apb_mem_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_err;

    apb_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_CYCLES(2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .apb        (bus),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .i_mem_err  (mem_err)
    );

    // Words 0..7 are write-protected.
    function automatic bit is_prot(input int unsigned w);
        return w < 8;
    endfunction

    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] ref_mem [2**AW];

    assign mem_rdata = mem[mem_addr];
    assign mem_err   = mem_we && is_prot(32'(mem_addr));

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 32'(i);
        end else if (mem_we && !is_prot(32'(mem_addr))) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int   errors = 0;
    int   checks = 0;
    int   we_cnt = 0;
    int   exp_we = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per completed transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mem_we) we_cnt++;
            if (mem_we && !bus.pready) check("we_without_pready", 32'(mem_we), 32'd0);
            if (bus.pready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pready", 32'(bus.pready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pslverr", 32'(bus.pslverr), 32'(e.err));
                    check("prdata", bus.prdata, e.data);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t          e;
        bit            derr;
        logic [AW-1:0] widx;
        int            n;
        widx   = addr[AW+1:2];
        derr   = (addr[1:0] != 2'b00) || (addr >= 32'(4 * (2**AW)));
        e.err  = derr || (wr && is_prot(32'(widx)));
        e.data = (!wr && !derr) ? ref_mem[widx] : 32'd0;
        if (wr && !derr) exp_we++;
        if (wr && !e.err) ref_mem[widx] = data;
        exp_q.push_back(e);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = data;
        @(posedge clk);
        #1 bus.penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pready && n < 20);
        if (!bus.pready) check("pready_timeout", 32'd0, 32'd1);
        else check("latency", 32'(n), 32'(WAIT_EFF + 2));
        @(posedge clk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int          base;
        int unsigned kind;
        int unsigned word;
        logic [31:0] addr;
        rst         = 1'b1;
        mem_init    = 1'b1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'd0;
        bus.pwdata  = 32'd0;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = 32'(i);
        repeat (2) @(posedge clk);
        #1;
        bus.psel   = 1'b1;
        bus.pwrite = 1'b1;
        bus.paddr  = 32'h104;
        bus.pwdata = 32'h0000_FFFF;
        @(negedge clk);
        check("rst_pready", 32'(bus.pready), 32'd0);
        check("rst_pslverr", 32'(bus.pslverr), 32'd0);
        check("rst_prdata", bus.prdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        idle(1);

        // Reset during a write to 0x100 abandons it.
        bus.psel    = 1'b1;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h100;
        bus.pwdata  = 32'hCAFE_0000;
        @(posedge clk);
        #1 bus.penable = 1'b1;
        if (WAIT_EFF > 0) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_pready", 32'(bus.pready), 32'd0);
            check("midrst_mem_we", 32'(mem_we), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        xfer(1'b0, 32'h100, 32'd0);

        xfer(1'b1, 32'h104, 32'hDEAD_BEEF);
        idle(1);
        xfer(1'b0, 32'h104, 32'd0);
        xfer(1'b1, 32'h008, 32'h1234_5678);
        xfer(1'b0, 32'h008, 32'd0);
        xfer(1'b0, 32'h202, 32'd0);
        xfer(1'b0, 32'h200, 32'd0);

        base = we_cnt;
        xfer(1'b1, 32'h100, 32'h1111_0100);
        xfer(1'b1, 32'h104, 32'h2222_0104);
        check("b2b_we_pulses", 32'(we_cnt - base), 32'd2);
        xfer(1'b0, 32'h0FC, 32'd0);

        // psel & penable straight from IDLE must be ignored.
        idle(1);
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h10C;
        repeat (3) begin
            @(negedge clk);
            check("idle_violation_pready", 32'(bus.pready), 32'd0);
            check("idle_violation_we", 32'(mem_we), 32'd0);
        end
        @(posedge clk);
        #1;
        idle(1);

        repeat (60) begin
            kind = $urandom_range(0, 9);
            word = (kind < 5) ? $urandom_range(0, 15) : $urandom_range(0, 127);
            addr = 32'(word) << 2;
            if (kind == 0) addr = addr | 32'($urandom_range(1, 3));
            if (kind == 1) addr = addr | ($urandom & 32'hFFFF_FE00) | 32'h200;
            xfer(1'($urandom_range(0, 1)), addr, $urandom);
            base = int'($urandom_range(0, 2));
            if (base > 0) idle(base);
        end

        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("we_total", 32'(we_cnt), 32'(exp_we));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
